// File: rtl/qbus_slave_sequencer_pkg.sv
// Shared types and constants for the Qbus slave sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qbus_slave_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SKIP     = 3'd1,
        SEL      = 3'd2,
        RD_SETUP = 3'd3,
        RD_REPLY = 3'd4,
        RD_HOLD  = 3'd5,
        WR       = 3'd6
    } state_t;

    localparam int          NUM_REGS      = 4;
    localparam logic [21:0] QADDR_DEFAULT = 22'o17772150;

    // Byte-lane merge used by both the Qbus and FMC write paths; be[0] covers bits 7:0.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_dat,
                                                input logic [15:0] new_dat,
                                                input logic [1:0]  be);
        merge_bytes = old_dat;
        if (be[0]) merge_bytes[7:0]  = new_dat[7:0];
        if (be[1]) merge_bytes[15:8] = new_dat[15:8];
    endfunction

endpackage

// File: rtl/qbus_slave_sequencer_if.sv
// Qbus pin-side strobes/data plus the FMC register-port request bundle.
// Latency: n/a (wiring only).
// Backpressure: FMC holds fmc_req until fmc_ack; Qbus side is paced by BRPLY.
interface qbus_slave_sequencer_if;

    logic        bsync_n;
    logic        bdin_n;
    logic        bdout_n;
    logic        bwtbt_n;
    logic        binit_n;
    logic [21:0] qaddr_lat;
    logic        bs7_lat;
    logic [15:0] bdal_in;
    logic [15:0] bdal_out;
    logic        bdal_oe;
    logic        outbound;
    logic        brply_g;

    logic        fmc_req;
    logic        fmc_we;
    logic [1:0]  fmc_addr;
    logic [1:0]  fmc_be;
    logic [15:0] fmc_wdata;
    logic        fmc_ack;
    logic [15:0] fmc_rdata;

    modport slave (
        input  bsync_n, bdin_n, bdout_n, bwtbt_n, binit_n,
        input  qaddr_lat, bs7_lat, bdal_in,
        output bdal_out, bdal_oe, outbound, brply_g,
        input  fmc_req, fmc_we, fmc_addr, fmc_be, fmc_wdata,
        output fmc_ack, fmc_rdata
    );

    modport master (
        output bsync_n, bdin_n, bdout_n, bwtbt_n, binit_n,
        output qaddr_lat, bs7_lat, bdal_in,
        input  bdal_out, bdal_oe, outbound, brply_g,
        output fmc_req, fmc_we, fmc_addr, fmc_be, fmc_wdata,
        input  fmc_ack, fmc_rdata
    );

endinterface

// File: rtl/qbus_slave_sequencer_sync.sv
// Multi-flop synchroniser for one asynchronous strobe, reset to a chosen level.
// Latency: STAGES clocks from input change to output change.
// Backpressure: none.
module qbus_slave_sequencer_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift chain; reset forces the strobe to its deasserted level.
    always_ff @(posedge clock) begin
        if (!resetn) ff <= {STAGES{RST_VAL}};
        else         ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/qbus_slave_sequencer.sv
// Qbus slave-cycle sequencer for a 4x16 CSR file, sharing its single port with the FMC bridge.
// Latency: SYNC_STAGES+1 clocks strobe->response; BRPLY follows BDAL drive by SETUP_CYCLES.
// Backpressure: Qbus owns the port one cycle per strobe; FMC then waits at most 2 cycles for fmc_ack.
module qbus_slave_sequencer
    import qbus_slave_sequencer_pkg::*;
#(
    parameter logic [21:0] QADDR        = QADDR_DEFAULT,
    parameter int          SYNC_STAGES  = 2,
    parameter int          SETUP_CYCLES = 2,
    parameter int          HOLD_CYCLES  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    qbus_slave_sequencer_if.slave bus,
    output logic [15:0]           reg0
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    // Raw strobes, all active-low: {binit, bwtbt, bdout, bdin, bsync}.
    logic [4:0] raw_n;
    logic [4:0] syn_n;
    assign raw_n = {bus.binit_n, bus.bwtbt_n, bus.bdout_n, bus.bdin_n, bus.bsync_n};

    for (genvar i = 0; i < 5; i++) begin : g_sync
        qbus_slave_sequencer_sync #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (1'b1)
        ) u_sync (
            .clock  (clock),
            .resetn (resetn),
            .d      (raw_n[i]),
            .q      (syn_n[i])
        );
    end

    logic sync, din, dout, wtbt, init;
    assign sync = ~syn_n[0];
    assign din  = ~syn_n[1];
    assign dout = ~syn_n[2];
    assign wtbt = ~syn_n[3];
    assign init = ~syn_n[4];

    logic       sel;
    logic [1:0] idx;
    assign sel = bus.bs7_lat && (bus.qaddr_lat[12:3] == QADDR[12:3]);
    assign idx = bus.qaddr_lat[2:1];

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] bdal_out_q;
    logic        oe_q;
    logic        brply_q;
    logic        fmc_ack_q;
    logic [15:0] fmc_rdata_q;
    logic [15:0] regs [NUM_REGS];

    // Qbus takes the port on the SEL cycle that launches a read or write; FMC gets every other cycle.
    logic       qbus_rd, qbus_wr, qbus_port, fmc_grant;
    logic [1:0] qbus_be;
    assign qbus_rd   = (state == SEL) && din && !init;
    assign qbus_wr   = (state == SEL) && !din && dout && !init;
    assign qbus_port = qbus_rd || qbus_wr;
    assign fmc_grant = bus.fmc_req && !qbus_port && !fmc_ack_q;
    assign qbus_be   = wtbt ? (bus.qaddr_lat[0] ? 2'b10 : 2'b01) : 2'b11;

    // Register file write port: BINIT clears, otherwise Qbus or granted FMC write.
    always_ff @(posedge clock) begin
        if (!resetn || init) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (qbus_wr) begin
            regs[idx] <= merge_bytes(regs[idx], bus.bdal_in, qbus_be);
        end else if (fmc_grant && bus.fmc_we) begin
            regs[bus.fmc_addr] <= merge_bytes(regs[bus.fmc_addr], bus.fmc_wdata, bus.fmc_be);
        end
    end

    // FMC completion: ack one cycle after grant, independent of BINIT so no request is stranded.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            fmc_ack_q   <= 1'b0;
            fmc_rdata_q <= '0;
        end else begin
            fmc_ack_q <= fmc_grant;
            if (fmc_grant) fmc_rdata_q <= regs[bus.fmc_addr];
        end
    end

    // Slave-cycle FSM with registered BDAL drive, direction and BRPLY outputs.
    always_ff @(posedge clock) begin
        if (!resetn || init) begin
            state      <= IDLE;
            cnt        <= '0;
            bdal_out_q <= '0;
            oe_q       <= 1'b0;
            brply_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync) state <= sel ? SEL : SKIP;
                end
                SKIP: begin
                    if (!sync) state <= IDLE;
                end
                SEL: begin
                    if (din) begin
                        state      <= RD_SETUP;
                        bdal_out_q <= regs[idx];
                        oe_q       <= 1'b1;
                        cnt        <= '0;
                    end else if (dout) begin
                        state <= WR;
                    end else if (!sync) begin
                        state <= IDLE;
                    end
                end
                RD_SETUP: begin
                    if (!din) begin
                        state <= RD_HOLD;
                        cnt   <= '0;
                    end else if (cnt == SETUP_LAST) begin
                        state   <= RD_REPLY;
                        brply_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD_REPLY: begin
                    if (!din) begin
                        state   <= RD_HOLD;
                        brply_q <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RD_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        oe_q  <= 1'b0;
                        state <= sync ? SEL : IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WR: begin
                    if (!dout) begin
                        brply_q <= 1'b0;
                        state   <= sync ? SEL : IDLE;
                    end else begin
                        brply_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bdal_out  = bdal_out_q;
    assign bus.bdal_oe   = oe_q;
    assign bus.outbound  = oe_q;
    assign bus.brply_g   = brply_q;
    assign bus.fmc_ack   = fmc_ack_q;
    assign bus.fmc_rdata = fmc_rdata_q;
    assign reg0          = regs[0];

endmodule

// File: tb/tb_qbus_slave_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized traffic vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_qbus_slave_sequencer;

    localparam int          SETUP = 2;
    localparam int          HOLD  = 1;
    localparam logic [21:0] QBASE = 22'o17772150;

    logic        clock;
    logic        resetn;
    logic [15:0] reg0;

    qbus_slave_sequencer_if bus ();

    qbus_slave_sequencer #(
        .QADDR        (QBASE),
        .SYNC_STAGES  (2),
        .SETUP_CYCLES (SETUP),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus),
        .reg0   (reg0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Bus monitor: running counts only, read as deltas by the stimulus.
    int   oe_cycles = 0;
    int   rp_rise   = 0;
    int   ob_err    = 0;
    logic rp_prev   = 1'b0;
    always @(negedge clock) begin
        if (bus.bdal_oe === 1'b1) oe_cycles++;
        if (bus.brply_g === 1'b1 && !rp_prev) rp_rise++;
        if (bus.outbound !== bus.bdal_oe) ob_err++;
        rp_prev = (bus.brply_g === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fmc_access(input logic we, input logic [1:0] a, input logic [1:0] be,
                              input logic [15:0] wd, output logic [15:0] rd, output int lat);
        bus.fmc_we = we; bus.fmc_addr = a; bus.fmc_be = be; bus.fmc_wdata = wd;
        bus.fmc_req = 1'b1;
        lat = 99; rd = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bus.fmc_ack) begin lat = i; rd = bus.fmc_rdata; break; end
        end
        bus.fmc_req = 1'b0;
        tick();
    endtask

    task automatic qbus_addr(input logic [21:0] a, input logic b7);
        bus.qaddr_lat = a; bus.bs7_lat = b7;
        tick();
        bus.bsync_n = 1'b0;
        repeat (3) tick();
    endtask

    task automatic qbus_end();
        bus.bsync_n = 1'b1;
        repeat (4) tick();
        bus.bs7_lat = 1'b0;
    endtask

    task automatic qbus_read_phase(output logic got, output logic [15:0] data,
                                   output int setup, output int hold);
        int t_oe, t_rp, t_rl, t_ol;
        got = 1'b0; data = '0; setup = -1; hold = -1; t_oe = -1; t_rp = -1; t_rl = -1; t_ol = -1;
        bus.bdin_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.bdal_oe && t_oe < 0) t_oe = i;
            if (bus.brply_g) begin t_rp = i; got = 1'b1; data = bus.bdal_out; break; end
        end
        if (got) setup = t_rp - t_oe;
        bus.bdin_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!bus.brply_g && t_rl < 0) t_rl = i;
            if (!bus.bdal_oe) begin t_ol = i; break; end
        end
        if (got) hold = t_ol - t_rl;
    endtask

    task automatic qbus_write_phase(input logic byte_w, input logic [15:0] d,
                                    output logic got, output logic held);
        logic dropped;
        bus.bwtbt_n = !byte_w; bus.bdal_in = d;
        tick();
        bus.bdout_n = 1'b0;
        got = 1'b0; held = 1'b1; dropped = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.brply_g) begin got = 1'b1; break; end
        end
        if (got) repeat (2) begin tick(); if (!bus.brply_g) held = 1'b0; end
        bus.bdout_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!bus.brply_g) begin dropped = 1'b1; break; end
        end
        if (!dropped) held = 1'b0;
        bus.bwtbt_n = 1'b1;
    endtask

    // Reference register contents, updated only from the access rules.
    logic [15:0] mdl [4];

    function automatic logic [15:0] lane_write(input logic [15:0] old, input logic [15:0] d,
                                               input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    typedef struct {
        logic        wr;
        logic [21:0] addr;
        logic        bs7;
        logic        byte_w;
        logic [15:0] wdata;
        logic        exp_rply;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic run_random(input int iters);
        int          kind, q_idx, f_idx, f_delay, lat, setup, hold, oe0;
        logic        match, bsel, b7, do_f, f_we, got, held;
        logic [1:0]  f_be;
        logic [15:0] wd, f_wd, rdq, rdf;
        logic [21:0] a;
        for (int it = 0; it < iters; it++) begin
            kind  = $urandom_range(0, 2);
            q_idx = $urandom_range(0, 3);
            match = ($urandom_range(0, 3) != 0);
            bsel  = (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            wd    = 16'($urandom);
            if (match) begin
                a = QBASE + 22'(q_idx * 2) + 22'(bsel); b7 = 1'b1;
            end else if ($urandom_range(0, 1) == 0) begin
                a = QBASE + 22'(q_idx * 2) + 22'(bsel); b7 = 1'b0;
            end else begin
                a = 22'o17772200 + 22'(q_idx * 2) + 22'(bsel); b7 = 1'b1;
            end
            do_f    = 1'($urandom_range(0, 1));
            f_idx   = (q_idx + $urandom_range(1, 3)) % 4;
            f_we    = 1'($urandom_range(0, 1));
            f_be    = 2'($urandom_range(1, 3));
            f_wd    = 16'($urandom);
            f_delay = $urandom_range(0, 8);
            oe0     = oe_cycles;
            got = 1'b0; rdq = '0; rdf = '0; lat = 0;
            fork
                begin
                    qbus_addr(a, b7);
                    if (kind == 0) qbus_read_phase(got, rdq, setup, hold);
                    else           qbus_write_phase(kind == 2, wd, got, held);
                    qbus_end();
                end
                begin
                    if (do_f) begin
                        repeat (f_delay) tick();
                        fmc_access(f_we, 2'(f_idx), f_be, f_wd, rdf, lat);
                    end
                end
            join
            check("rnd_reply", got, match);
            if (!match) check("rnd_no_oe", oe_cycles - oe0, 0);
            if (match && kind == 0) check("rnd_qbus_rdata", rdq, mdl[q_idx]);
            if (match && kind == 1) mdl[q_idx] = wd;
            if (match && kind == 2) mdl[q_idx] = lane_write(mdl[q_idx], wd, bsel ? 2'b10 : 2'b01);
            if (do_f) begin
                check("rnd_fmc_lat", (lat >= 1 && lat <= 2), 1'b1);
                if (!f_we) check("rnd_fmc_rdata", rdf, mdl[f_idx]);
                else       mdl[f_idx] = lane_write(mdl[f_idx], f_wd, f_be);
            end
        end
    endtask

    initial begin
        logic        got, held;
        logic [15:0] data;
        int          setup, hold, lat, oe0, rp0;

        vecs[0]  = '{1'b0, 22'o17772154, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234};
        vecs[1]  = '{1'b1, 22'o17772151, 1'b1, 1'b1, 16'hAB00, 1'b1, 16'h0000};
        vecs[2]  = '{1'b0, 22'o17772150, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD};
        vecs[3]  = '{1'b1, 22'o17772156, 1'b1, 1'b0, 16'h0F0F, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 22'o17772156, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0F0F};
        vecs[5]  = '{1'b1, 22'o17772152, 1'b1, 1'b1, 16'h5577, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 22'o17772152, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0077};
        vecs[7]  = '{1'b0, 22'o17772200, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 22'o17772200, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 22'o17772150, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 22'o17772150, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD};
        vecs[11] = '{1'b1, 22'o17772157, 1'b1, 1'b1, 16'h3300, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 22'o17772156, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h330F};

        bus.bsync_n = 1'b1; bus.bdin_n = 1'b1; bus.bdout_n = 1'b1; bus.bwtbt_n = 1'b1;
        bus.binit_n = 1'b1; bus.qaddr_lat = '0; bus.bs7_lat = 1'b0; bus.bdal_in = '0;
        bus.fmc_req = 1'b0; bus.fmc_we = 1'b0; bus.fmc_addr = '0; bus.fmc_be = '0;
        bus.fmc_wdata = '0;
        resetn = 1'b0;
        repeat (4) tick();
        check("rst_bdal_oe", bus.bdal_oe, 1'b0);
        check("rst_outbound", bus.outbound, 1'b0);
        check("rst_brply", bus.brply_g, 1'b0);
        check("rst_bdal_out", bus.bdal_out, 16'h0);
        check("rst_fmc_ack", bus.fmc_ack, 1'b0);
        check("rst_reg0", reg0, 16'h0);
        resetn = 1'b1;
        repeat (3) tick();

        fmc_access(1'b1, 2'd2, 2'b11, 16'h1234, data, lat);
        check("preload_lat", lat, 1);
        fmc_access(1'b1, 2'd0, 2'b11, 16'h00CD, data, lat);
        check("preload_lat0", lat, 1);

        // Directed single-strobe cycles from the vector table.
        for (int v = 0; v < 13; v++) begin
            oe0 = oe_cycles; rp0 = rp_rise;
            qbus_addr(vecs[v].addr, vecs[v].bs7);
            if (vecs[v].wr) begin
                qbus_write_phase(vecs[v].byte_w, vecs[v].wdata, got, held);
                check($sformatf("vec%0d_reply", v), got, vecs[v].exp_rply);
                if (vecs[v].exp_rply) check($sformatf("vec%0d_wr_reply_held", v), held, 1'b1);
            end else begin
                qbus_read_phase(got, data, setup, hold);
                check($sformatf("vec%0d_reply", v), got, vecs[v].exp_rply);
                if (vecs[v].exp_rply) begin
                    check($sformatf("vec%0d_rdata", v), data, vecs[v].exp_rdata);
                    check($sformatf("vec%0d_setup", v), setup, SETUP);
                    check($sformatf("vec%0d_hold", v), hold, HOLD);
                end
            end
            qbus_end();
            if (!vecs[v].exp_rply) begin
                check($sformatf("vec%0d_no_oe", v), oe_cycles - oe0, 0);
                check($sformatf("vec%0d_no_brply", v), rp_rise - rp0, 0);
            end
        end
        check("reg0_after_datob", reg0, 16'hABCD);

        // Same-cycle collision on reg1: Qbus word write AAAA, FMC write 5555 lands afterwards.
        qbus_addr(22'o17772152, 1'b1);
        bus.bwtbt_n = 1'b1; bus.bdal_in = 16'hAAAA;
        tick();
        bus.bdout_n = 1'b0;
        repeat (2) tick();
        bus.fmc_we = 1'b1; bus.fmc_addr = 2'd1; bus.fmc_be = 2'b11; bus.fmc_wdata = 16'h5555;
        bus.fmc_req = 1'b1;
        lat = 99;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bus.fmc_ack) begin lat = i; break; end
        end
        bus.fmc_req = 1'b0;
        check("collide_fmc_lat", lat, 2);
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.brply_g) begin got = 1'b1; break; end
            tick();
        end
        check("collide_qbus_reply", got, 1'b1);
        bus.bdout_n = 1'b1;
        repeat (4) tick();
        qbus_end();
        fmc_access(1'b0, 2'd1, 2'b11, 16'h0, data, lat);
        check("collide_final_reg1", data, 16'h5555);

        // DATIO on reg3 within a single BSYNC.
        rp0 = rp_rise;
        qbus_addr(22'o17772156, 1'b1);
        qbus_read_phase(got, data, setup, hold);
        check("datio_rd_reply", got, 1'b1);
        check("datio_rd_data", data, 16'h330F);
        qbus_write_phase(1'b0, 16'h1111, got, held);
        check("datio_wr_reply", got, 1'b1);
        qbus_end();
        check("datio_pulses", rp_rise - rp0, 2);
        fmc_access(1'b0, 2'd3, 2'b11, 16'h0, data, lat);
        check("datio_reg3", data, 16'h1111);

        // BINIT during RD_REPLY.
        fmc_access(1'b1, 2'd0, 2'b11, 16'h1357, data, lat);
        qbus_addr(22'o17772154, 1'b1);
        bus.bdin_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.brply_g) begin got = 1'b1; break; end
        end
        check("binit_pre_reply", got, 1'b1);
        bus.binit_n = 1'b0;
        repeat (2) tick();
        check("binit_brply_before_sync", bus.brply_g, 1'b1);
        tick();
        check("binit_brply_low", bus.brply_g, 1'b0);
        check("binit_oe_low", bus.bdal_oe, 1'b0);
        check("binit_reg0_clear", reg0, 16'h0);
        fmc_access(1'b0, 2'd2, 2'b11, 16'h0, data, lat);
        check("binit_fmc_lat", lat, 1);
        check("binit_reg2_clear", data, 16'h0);
        oe0 = oe_cycles;
        bus.bdin_n = 1'b1;
        qbus_end();
        bus.binit_n = 1'b1;
        repeat (4) tick();
        check("binit_idle_no_oe", oe_cycles - oe0, 0);

        for (int i = 0; i < 4; i++) mdl[i] = '0;
        run_random(40);
        for (int i = 0; i < 4; i++) begin
            fmc_access(1'b0, 2'(i), 2'b11, 16'h0, data, lat);
            check($sformatf("final_reg%0d", i), data, mdl[i]);
        end
        check("final_reg0_port", reg0, mdl[0]);
        check("outbound_eq_oe", ob_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
